// File: rtl/dds_serial_capture.sv
// Rebuilds 40-bit DDS serial load words (LSB first) from the async DDS lines and queues them.
// Latency: pin edge -> internal pulse 3 CLKA edges; strobed word visible at the head 1 cycle after the push.
// Backpressure: none toward the DDS lines; a good frame arriving at a full FIFO is dropped and flagged.
module dds_serial_capture #(
    parameter int FRAME_BITS = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLKA,
    input  logic        reset,
    input  logic        ddswclk,
    input  logic        ddsfqud,
    input  logic        ddsreset,
    input  logic        ddsdata,
    input  logic        rd_en,
    input  logic        err_clr,
    output logic        word_valid,
    output logic [31:0] freq_word,
    output logic [7:0]  ctrl_word,
    output logic [2:0]  fifo_cnt,
    output logic        frame_err,
    output logic        ovf_err,
    output logic [15:0] frames_total
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Line index within the synchronizer vectors: 0 wclk, 1 fqud, 2 ddsreset, 3 data.
    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            edge_q,  edge_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [FRAME_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  frame_err_q, frame_err_d;
    logic                  ovf_err_q, ovf_err_d;
    logic [15:0]           frames_total_q, frames_total_d;

    logic wclk_rise, fqud_rise, dds_rst, dbit;
    logic frame_good, frame_bad, fifo_full, pop, push, ovf_set;
    logic [FRAME_BITS-1:0] head;

    // Input conditioning, frame assembly, length check, FIFO and flag next-state.
    always_comb begin
        sync1_d = {ddsdata, ddsreset, ddsfqud, ddswclk};
        sync2_d = sync1_q;
        edge_d  = sync2_q;

        wclk_rise = sync2_q[0] & ~edge_q[0];
        fqud_rise = sync2_q[1] & ~edge_q[1];
        dds_rst   = sync2_q[2];
        // Data taken at the same sync depth as wclk so the bit lines up with its clock edge.
        dbit      = sync2_q[3];

        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;

        if (dds_rst) begin
            sr_d      = '0;
            bit_cnt_d = '0;
        end else begin
            if (wclk_rise) begin
                sr_d = {dbit, sr_q[FRAME_BITS-1:1]};
                if (bit_cnt_q != 6'd63) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            // Length check sees the bit that may have arrived in this same cycle.
            if (fqud_rise) begin
                if (bit_cnt_d == 6'(FRAME_BITS)) begin
                    frame_good = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                end
                bit_cnt_d = '0;
            end
        end

        fifo_full = (cnt_q == 3'(FIFO_DEPTH));
        pop       = rd_en && (cnt_q != 3'd0);
        push      = frame_good && (!fifo_full || pop);
        ovf_set   = frame_good && fifo_full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = sr_d;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 3'd1;
        end

        // Clear first so a coincident set event wins.
        frame_err_d = frame_err_q;
        ovf_err_d   = ovf_err_q;
        if (err_clr) begin
            frame_err_d = 1'b0;
            ovf_err_d   = 1'b0;
        end
        if (frame_bad) begin
            frame_err_d = 1'b1;
        end
        if (ovf_set) begin
            ovf_err_d = 1'b1;
        end

        // Counts every accepted frame, including one dropped for lack of space.
        frames_total_d = frames_total_q + 16'(frame_good);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLKA or posedge reset) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            edge_q         <= '0;
            sr_q           <= '0;
            bit_cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            frame_err_q    <= 1'b0;
            ovf_err_q      <= 1'b0;
            frames_total_q <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            edge_q         <= edge_d;
            sr_q           <= sr_d;
            bit_cnt_q      <= bit_cnt_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            frame_err_q    <= frame_err_d;
            ovf_err_q      <= ovf_err_d;
            frames_total_q <= frames_total_d;
        end
    end

    // Show-ahead head, forced to zero when empty.
    assign head         = (cnt_q != 3'd0) ? mem_q[rd_ptr_q] : '0;
    assign word_valid   = (cnt_q != 3'd0);
    assign freq_word    = head[31:0];
    assign ctrl_word    = head[39:32];
    assign fifo_cnt     = cnt_q;
    assign frame_err    = frame_err_q;
    assign ovf_err      = ovf_err_q;
    assign frames_total = frames_total_q;

endmodule

// File: doc/dds_serial_capture.md
# dds_serial_capture

Receive-side counterpart of the DDS serial loader in the frequency-scan path. It monitors the four DDS programming lines (`ddswclk`, `ddsfqud`, `ddsreset`, `ddsdata`) and rebuilds each 40-bit serial load word, LSB first. Each word is checked for length on the `ddsfqud` strobe and queued in a small FIFO that the DSP reads over the local bus. It serves as both an on-board loopback monitor and a bench checker for every frequency step of a scan.

## Interface
Parameters:
- `FRAME_BITS`, 40, number of serial bits per DDS load word.
- `FIFO_DEPTH`, 4, number of captured words held; must be a power of 2.

Ports:
- `CLKA`  in  1  system clock; all logic runs in this domain.
- `reset`  in  1  asynchronous, active-high reset.
- `ddswclk`  in  1  DDS serial word clock; asynchronous to `CLKA`.
- `ddsfqud`  in  1  DDS frequency-update strobe; asynchronous.
- `ddsreset`  in  1  DDS reset line; asynchronous.
- `ddsdata`  in  1  DDS serial data; asynchronous.
- `rd_en`  in  1  one-cycle pop request from the DSP bus decoder.
- `err_clr`  in  1  one-cycle clear of the sticky error flags.
- `word_valid`  out  1  FIFO not empty.
- `freq_word`  out  32  head entry, bits [31:0]: the tuning word.
- `ctrl_word`  out  8  head entry, bits [39:32]: phase, power-down and control bits.
- `fifo_cnt`  out  3  number of entries held, 0..`FIFO_DEPTH`.
- `frame_err`  out  1  sticky; set when a strobed frame length is not `FRAME_BITS`.
- `ovf_err`  out  1  sticky; set when a good frame is dropped because the FIFO is full.
- `frames_total`  out  16  count of accepted frames; wraps from 0xFFFF to 0.

## Operation
- Input conditioning:
  - All four DDS lines pass through 2-FF synchronizers, then a third register for edge detection.
  - `wclk_rise` and `fqud_rise` are single-cycle pulses.
  - `ddsdata` is sampled from its own synchronized copy, which has the same delay as the `ddswclk` path.
- Shift register and bit counter:
  - On `wclk_rise`, the synchronized data bit enters `sr[39]` and `sr` shifts right. After 40 bits, the first bit received sits in `sr[0]`.
  - A 6-bit counter increments on every `wclk_rise` and saturates at 63.
- Frame end on `fqud_rise`:
  - If count == `FRAME_BITS`, `sr` is pushed to the FIFO and `frames_total` increments.
  - Otherwise `frame_err` is set and nothing is pushed.
  - In both cases the counter clears; `sr` is not cleared.
- Simultaneous `wclk_rise` and `fqud_rise`: the bit is shifted in and counted first, then the length check uses the updated count.
- `ddsreset` high (synchronized level):
  - Clears `sr` and the bit counter.
  - Edges on `ddswclk` and `ddsfqud` are ignored while it is high.
  - The FIFO, flags and `frames_total` are not affected.
- FIFO behaviour:
  - Show-ahead: `freq_word`/`ctrl_word` always present the head entry and read 0 when empty.
  - `rd_en` while empty is ignored.
  - Push and pop in the same cycle, when full: both happen, `fifo_cnt` stays at `FIFO_DEPTH`, and no overflow is flagged.
  - Push while full without a pop: the frame is dropped, `ovf_err` is set, and `frames_total` still increments.
  - Push and pop in the same cycle, when empty: the push happens and the pop is ignored.
- Sticky flags:
  - `err_clr` clears `frame_err` and `ovf_err`.
  - If a set event occurs in the same cycle as `err_clr`, the set wins.
- Reset values: all outputs are 0, the FIFO is empty, and `sr`, the counter and the synchronizers are 0.

## Timing
- Latency from an input edge to its internal pulse:
  - Input edge at the pins → `*_rise` pulse 3 `CLKA` edges later (2 sync + 1 edge stage).
  - The shift happens on that same edge.
- Latency from the strobe to visible data:
  - If `fqud_rise` is asserted in cycle N, the FIFO write and `frames_total` update complete at the end of N.
  - `word_valid` goes high and the head appears in cycle N+1.
- `rd_en` in cycle M pops at the end of M; the next head, or 0 if empty, appears in M+1.
- Input constraints:
  - `ddswclk` and `ddsfqud` high and low times must each be at least 2 `CLKA` periods.
  - `ddsdata` must be stable from 1 `CLKA` period before the `ddswclk` rising edge to 1 period after it.
- Async `reset` takes effect immediately. Asserting it mid-frame discards the partial word and all FIFO contents.

## Test plan
- Send 40 bits for frequency word 0x0147AE14 with control byte 0x00, LSB first, then pulse `ddsfqud` → `word_valid`=1, `freq_word`=0x0147AE14, `ctrl_word`=0x00, `fifo_cnt`=1, `frames_total`=1. Then `rd_en` → `word_valid`=0 and `freq_word`=0 the next cycle.
- Send 39 bits then `ddsfqud` → `frame_err`=1, `fifo_cnt`=0. Send 41 bits then `ddsfqud` → `frame_err` stays 1, no push. `err_clr` → `frame_err`=0.
- Send 5 good frames with words 1..5 and no reads → `fifo_cnt`=4, head=1, `ovf_err`=1, `frames_total`=5. Four pops return 1, 2, 3, 4.
- FIFO full; `rd_en` in the same cycle as a `fqud_rise` carrying word 9 → `fifo_cnt` stays 4, `ovf_err` stays 0, and word 9 is read last.
- Send 20 bits, pulse `ddsreset`, then send a full 40-bit frame for 0xFFFFFFFF with control byte 0xA5 and strobe → exactly one entry: 0xFFFFFFFF / 0xA5, `frame_err`=0.
- Assert `reset` with 2 entries queued and 10 bits shifted → all outputs are 0 on the next cycle; a following good frame is captured normally.
